// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Captures decoded operands and control from ID, detects load-use hazards
// against the instruction already in EX, inserts a single bubble per hazard,
// and gates the PC / IF-ID write enables. A saturating counter records how
// many load-use bubbles have been inserted.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              flush,
  input  logic [4:0]        IF_ID_rs,
  input  logic [4:0]        IF_ID_rt,
  input  logic [4:0]        IF_ID_rd,
  input  logic              IF_ID_uses_rt,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_ALUSrc,
  input  logic [3:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_rs_data,
  input  logic [DATA_W-1:0] ID_rt_data,
  input  logic [DATA_W-1:0] ID_imm,
  output logic [4:0]        ID_EX_rs,
  output logic [4:0]        ID_EX_rt,
  output logic [4:0]        ID_EX_rd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemToReg,
  output logic              ID_EX_ALUSrc,
  output logic [3:0]        ID_EX_ALUOp,
  output logic [DATA_W-1:0] ID_EX_rs_data,
  output logic [DATA_W-1:0] ID_EX_rt_data,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic              ID_EX_valid,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic hazard;

  // Load in EX whose destination feeds a source of the instruction in ID.
  // A load into $0 never stalls: $0 always reads as zero.
  assign hazard = ID_EX_valid && ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                  ((ID_EX_rt == IF_ID_rs) ||
                   (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

  assign PC_Write    = ~(hazard | ext_stall);
  assign IF_ID_Write = ~(hazard | ext_stall);

  // Pipeline register: freeze on ext_stall, bubble on flush/hazard, else capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      ID_EX_rs       <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd       <= '0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemToReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_ALUOp    <= '0;
      ID_EX_rs_data  <= '0;
      ID_EX_rt_data  <= '0;
      ID_EX_imm      <= '0;
      ID_EX_valid    <= 1'b0;
      stall_count    <= '0;
    end else if (ext_stall) begin
      // NOTE: leaving every register unassigned in a clocked branch just holds
      // the flops (a clock enable); it does not infer a latch.
    end else if (flush || hazard) begin
      // Bubble: control, register ids and valid cleared so forwarding can
      // never match it. Data fields are zeroed as well for a clean trace.
      ID_EX_rs       <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd       <= '0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_MemWrite <= 1'b0;
      ID_EX_MemToReg <= 1'b0;
      ID_EX_ALUSrc   <= 1'b0;
      ID_EX_ALUOp    <= '0;
      ID_EX_rs_data  <= '0;
      ID_EX_rt_data  <= '0;
      ID_EX_imm      <= '0;
      ID_EX_valid    <= 1'b0;
      // Only genuine load-use bubbles are counted; flush takes priority.
      if (!flush && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end else begin
      ID_EX_rs       <= IF_ID_rs;
      ID_EX_rt       <= IF_ID_rt;
      ID_EX_rd       <= ID_RegDst ? IF_ID_rd : IF_ID_rt;
      ID_EX_RegWrite <= ID_RegWrite;
      ID_EX_MemRead  <= ID_MemRead;
      ID_EX_MemWrite <= ID_MemWrite;
      ID_EX_MemToReg <= ID_MemToReg;
      ID_EX_ALUSrc   <= ID_ALUSrc;
      ID_EX_ALUOp    <= ID_ALUOp;
      ID_EX_rs_data  <= ID_rs_data;
      ID_EX_rt_data  <= ID_rt_data;
      ID_EX_imm      <= ID_imm;
      ID_EX_valid    <= 1'b1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection and bubble insertion. It captures decoded operands and control from ID and presents the EX-side fields, including ID_EX_rs, ID_EX_rt, ID_EX_MemWrite and the EX destination register, to the forwarding unit and the ALU. It also drives the PC/IF-ID write enables and keeps a stall counter for performance analysis.

Parameters:
DATA_W, 32, width of register-file operands and sign-extended immediate
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
ext_stall  input  1  global freeze from memory system; holds the whole pipeline
flush  input  1  branch/jump taken; squash instruction currently in ID
IF_ID_rs  input  5  rs field of instruction in ID
IF_ID_rt  input  5  rt field of instruction in ID
IF_ID_rd  input  5  rd field of instruction in ID
IF_ID_uses_rt  input  1  instruction in ID reads rt as a source (R-type, sw, beq/bne)
ID_RegDst  input  1  1: destination is rd; 0: destination is rt
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc  input  1 each  decoded control
ID_ALUOp  input  4  decoded ALU operation
ID_rs_data  input  DATA_W  register-file read port 1
ID_rt_data  input  DATA_W  register-file read port 2
ID_imm  input  DATA_W  sign-extended immediate
ID_EX_rs, ID_EX_rt  output  5  registered source fields
ID_EX_rd  output  5  registered destination (already muxed by RegDst)
ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc  output  1 each  registered control
ID_EX_ALUOp  output  4  registered ALU operation
ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm  output  DATA_W  registered operands
ID_EX_valid  output  1  1 = real instruction in EX; 0 = bubble
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register update enable
stall_count  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (async, rst=1): every registered output is 0. ID_EX_valid=0, stall_count=0. PC_Write and IF_ID_Write follow their combinational equations.
- hazard (combinational) = ID_EX_valid & ID_EX_MemRead & (ID_EX_rt!=0) & ((ID_EX_rt==IF_ID_rs) | (IF_ID_uses_rt & ID_EX_rt==IF_ID_rt)).
- PC_Write = IF_ID_Write = ~(hazard | ext_stall). Both are combinational with zero latency.
- Per rising edge, in priority order:
  1. ext_stall=1: all registers hold, including valid and counter. flush is ignored; its source holds flush until ext_stall drops.
  2. flush=1: load a bubble. All control bits, ALUOp, ID_EX_rs/rt/rd and ID_EX_valid are cleared. Data fields may load anything; spec value is 0. stall_count is unchanged.
  3. hazard=1: load a bubble as in step 2, and stall_count increments, saturating at 2^CNT_W-1. The ID instruction is held by IF_ID_Write=0.
  4. Otherwise, capture all ID inputs and set ID_EX_valid=1. ID_EX_rd = ID_RegDst ? IF_ID_rd : IF_ID_rt.
- Latency: one cycle from ID inputs to ID_EX outputs.
- A bubble must present RegWrite=0 and MemWrite=0, so forwarding never matches it. Clearing rd/rs/rt to 0 provides the same guarantee.
- Load-use produces exactly one bubble. The next cycle's ID_EX holds that bubble (valid=0), so hazard deasserts and the held instruction advances.
- A load whose rt is $0 never stalls.
- flush and hazard together: flush wins. The counter does not increment.
- Reset asserted mid-stall clears state immediately. The pipeline resumes with no pending bubble.

Test Plan:
- Reset: rst=1 with random inputs → all outputs 0, stall_count=0. After release with ext_stall=0 and no hazard, PC_Write=1.
- Normal capture: ID_RegDst=1, rd=5, rt=7, RegWrite=1, rs_data=0x1234 → next edge ID_EX_rd=5, ID_EX_rs_data=0x1234, valid=1. Repeat with RegDst=0 → ID_EX_rd=7.
- Load-use: EX holds lw (MemRead=1, rt=8, valid=1); ID has add rs=8 → PC_Write=0 and IF_ID_Write=0 the same cycle. Next edge: bubble (valid=0, RegWrite=0), stall_count=1. The following edge captures the add.
- No false stall: lw rt=0 vs rs=0 → no stall. lw rt=8 vs ID rt=8 with uses_rt=0 → no stall. Non-load rt=8 → no stall.
- Flush priority: flush=1 together with a hazard condition → bubble, stall_count unchanged. ext_stall=1 with flush=1 → all registers hold.
- Saturation: CNT_W=2, force 5 load-use stalls → stall_count ends at 3.
